// File: rtl/obi_pkg.sv
// Shared types and default widths for the OBI instruction/data arbiter.
// The optional OBI_ARB_RR_EN build switches the arbiter to round-robin.
package obi_pkg;

   localparam int unsigned OBI_ADDR_W          = 32;
   localparam int unsigned OBI_DATA_W          = 32;
   localparam int unsigned OBI_BE_W            = OBI_DATA_W / 8;
   localparam int unsigned OBI_MAX_OUTSTANDING = 2;

   typedef enum logic {
      OBI_ID_INSTR = 1'b0,
      OBI_ID_DATA  = 1'b1
   } obi_id_e;

   typedef struct packed {
      logic [OBI_ADDR_W-1:0] addr;
      logic                  we;
      logic [OBI_BE_W-1:0]   be;
      logic [OBI_DATA_W-1:0] wdata;
   } obi_req_t;

endpackage

// File: rtl/obi_id_fifo.sv
// In-order FIFO of 1-bit requester IDs; records who owns each outstanding
// transaction. Push when full and pop when empty are ignored.
module obi_id_fifo
   import obi_pkg::*;
#(
   parameter  int unsigned DEPTH = OBI_MAX_OUTSTANDING,
   localparam int unsigned CNT_W = $clog2(DEPTH + 1),
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  obi_id_e          id_i,
   input  logic             pop_i,
   output obi_id_e          head_o,
   output logic [CNT_W-1:0] count_o
);

   logic [DEPTH-1:0] mem_q;
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             push_ok, pop_ok;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign push_ok = push_i & (count_q != CNT_W'(DEPTH));
   assign pop_ok  = pop_i & (count_q != '0);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mem_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) begin
            mem_q[wr_ptr_q] <= id_i;
            wr_ptr_q        <= ptr_inc(wr_ptr_q);
         end
         if (pop_ok) begin
            rd_ptr_q <= ptr_inc(rd_ptr_q);
         end
         // Simultaneous push and pop leaves the count unchanged.
         case ({push_ok, pop_ok})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   assign head_o  = obi_id_e'(mem_q[rd_ptr_q]);
   assign count_o = count_q;

endmodule

// File: rtl/obi_mem_arbiter.sv
// Merges instruction and data OBI manager ports onto one shared OBI port with
// zero added latency. Define OBI_ARB_RR_EN for round-robin arbitration.
module obi_mem_arbiter
   import obi_pkg::*;
#(
   parameter  int unsigned MAX_OUTSTANDING = OBI_MAX_OUTSTANDING,
   parameter  int unsigned ADDR_W          = OBI_ADDR_W,
   parameter  int unsigned DATA_W          = OBI_DATA_W,
   localparam int unsigned BE_W            = DATA_W / 8,
   localparam int unsigned CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic              clk_i,
   input  logic              rst_ni,

   input  logic              i_req_i,
   output logic              i_gnt_o,
   input  logic [ADDR_W-1:0] i_addr_i,
   input  logic              i_we_i,
   input  logic [BE_W-1:0]   i_be_i,
   input  logic [DATA_W-1:0] i_wdata_i,
   output logic              i_rvalid_o,
   output logic [DATA_W-1:0] i_rdata_o,

   input  logic              d_req_i,
   output logic              d_gnt_o,
   input  logic [ADDR_W-1:0] d_addr_i,
   input  logic              d_we_i,
   input  logic [BE_W-1:0]   d_be_i,
   input  logic [DATA_W-1:0] d_wdata_i,
   output logic              d_rvalid_o,
   output logic [DATA_W-1:0] d_rdata_o,

   output logic              m_req_o,
   input  logic              m_gnt_i,
   output logic [ADDR_W-1:0] m_addr_o,
   output logic              m_we_o,
   output logic [BE_W-1:0]   m_be_o,
   output logic [DATA_W-1:0] m_wdata_o,
   input  logic              m_rvalid_i,
   input  logic [DATA_W-1:0] m_rdata_i,

   output logic              err_o
);

   // Handshake: a request transfers in the cycle where req and gnt are both
   // high; once req is raised the request fields must hold until that cycle.
   // Responses carry no back-pressure and return in grant order on rvalid.

   logic [CNT_W-1:0] count;
   obi_id_e          head_id;
   logic             full, pick_data, sel_data, accept, pop;
   logic             lock_q, lock_data_q, err_q;

`ifdef OBI_ARB_RR_EN
   logic rr_data_q;

   // Pointer names the port that wins the next contention.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)     rr_data_q <= 1'b1;
      else if (accept) rr_data_q <= ~sel_data;
   end

   assign pick_data = ~i_req_i | (d_req_i & rr_data_q);
`else
   assign pick_data = d_req_i | ~i_req_i;
`endif

   assign sel_data = lock_q ? lock_data_q : pick_data;
   assign full     = (count == CNT_W'(MAX_OUTSTANDING));
   assign m_req_o  = (i_req_i | d_req_i) & ~full;
   assign accept   = m_req_o & m_gnt_i;

   assign m_addr_o  = sel_data ? d_addr_i  : i_addr_i;
   assign m_we_o    = sel_data ? d_we_i    : i_we_i;
   assign m_be_o    = sel_data ? d_be_i    : i_be_i;
   assign m_wdata_o = sel_data ? d_wdata_i : i_wdata_i;

   assign i_gnt_o = accept & ~sel_data;
   assign d_gnt_o = accept & sel_data;

   assign pop        = m_rvalid_i & (count != '0);
   assign i_rvalid_o = pop & (head_id == OBI_ID_INSTR);
   assign d_rvalid_o = pop & (head_id == OBI_ID_DATA);
   assign i_rdata_o  = m_rdata_i;
   assign d_rdata_o  = m_rdata_i;
   assign err_o      = err_q;

   // A stalled request pins the selection so the shared fields stay stable.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         lock_q      <= 1'b0;
         lock_data_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         lock_q      <= m_req_o & ~m_gnt_i;
         lock_data_q <= sel_data;
         if (m_rvalid_i && count == '0) err_q <= 1'b1;
      end
   end

   obi_id_fifo #(
      .DEPTH (MAX_OUTSTANDING)
   ) u_id_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (accept),
      .id_i    (sel_data ? OBI_ID_DATA : OBI_ID_INSTR),
      .pop_i   (pop),
      .head_o  (head_id),
      .count_o (count)
   );

endmodule

// File: tb/tb_obi_mem_arbiter.sv
// Directed scoreboard bench for obi_mem_arbiter: expected grants and responses
// are queued by the driver and consumed by a negedge monitor.
module tb_obi_mem_arbiter;
   import obi_pkg::*;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned BW = DW / 8;

   logic          clk, rst_ni;
   logic          i_req, i_gnt, i_we, i_rvalid;
   logic [AW-1:0] i_addr;
   logic [BW-1:0] i_be;
   logic [DW-1:0] i_wdata, i_rdata;
   logic          d_req, d_gnt, d_we, d_rvalid;
   logic [AW-1:0] d_addr;
   logic [BW-1:0] d_be;
   logic [DW-1:0] d_wdata, d_rdata;
   logic          m_req, m_gnt, m_we, m_rvalid, err;
   logic [AW-1:0] m_addr;
   logic [BW-1:0] m_be;
   logic [DW-1:0] m_wdata, m_rdata;

   int checks = 0;
   int errors = 0;

   logic [1:0]  exp_gnt_q[$];   // one-hot {d_gnt, i_gnt}
   logic [32:0] exp_rsp_q[$];   // {is_data, rdata}

   obi_mem_arbiter #(
      .MAX_OUTSTANDING (2),
      .ADDR_W          (AW),
      .DATA_W          (DW)
   ) dut (
      .clk_i      (clk),
      .rst_ni     (rst_ni),
      .i_req_i    (i_req),
      .i_gnt_o    (i_gnt),
      .i_addr_i   (i_addr),
      .i_we_i     (i_we),
      .i_be_i     (i_be),
      .i_wdata_i  (i_wdata),
      .i_rvalid_o (i_rvalid),
      .i_rdata_o  (i_rdata),
      .d_req_i    (d_req),
      .d_gnt_o    (d_gnt),
      .d_addr_i   (d_addr),
      .d_we_i     (d_we),
      .d_be_i     (d_be),
      .d_wdata_i  (d_wdata),
      .d_rvalid_o (d_rvalid),
      .d_rdata_o  (d_rdata),
      .m_req_o    (m_req),
      .m_gnt_i    (m_gnt),
      .m_addr_o   (m_addr),
      .m_we_o     (m_we),
      .m_be_o     (m_be),
      .m_wdata_o  (m_wdata),
      .m_rvalid_i (m_rvalid),
      .m_rdata_i  (m_rdata),
      .err_o      (err)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- checking helpers ----------------
   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   task automatic expect_txn(input bit is_data, input logic [31:0] data);
      exp_gnt_q.push_back(is_data ? 2'b10 : 2'b01);
      exp_rsp_q.push_back({is_data, data});
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      if (rst_ni) begin
         if (i_gnt || d_gnt) begin
            if (exp_gnt_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL gnt_unexpected: got {d,i}=%b expected none", {d_gnt, i_gnt});
            end else begin
               check("gnt", 32'({d_gnt, i_gnt}), 32'(exp_gnt_q.pop_front()));
            end
         end
         if (i_rvalid || d_rvalid) begin
            if (exp_rsp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL rvalid_unexpected: got {d,i}=%b expected none", {d_rvalid, i_rvalid});
            end else begin
               logic [32:0] e;
               e = exp_rsp_q.pop_front();
               check("rvalid_route", 32'({d_rvalid, i_rvalid}), e[32] ? 32'd2 : 32'd1);
               check("i_rdata", i_rdata, e[31:0]);
               check("d_rdata", d_rdata, e[31:0]);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic idle();
      i_req = 1'b0; d_req = 1'b0; m_gnt = 1'b0; m_rvalid = 1'b0;
   endtask

   task automatic respond(input logic [31:0] data);
      idle();
      m_rvalid = 1'b1; m_rdata = data;
      cycle();
      m_rvalid = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst_ni = 1'b0;
      idle();
      i_addr = '0; i_we = 1'b0; i_be = 4'hF; i_wdata = '0;
      d_addr = '0; d_we = 1'b0; d_be = 4'hF; d_wdata = '0;
      m_rdata = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_m_req", 32'(m_req), 0);
      check("rst_i_gnt", 32'(i_gnt), 0);
      check("rst_d_gnt", 32'(d_gnt), 0);
      check("rst_i_rvalid", 32'(i_rvalid), 0);
      check("rst_d_rvalid", 32'(d_rvalid), 0);
      check("rst_err", 32'(err), 0);
      rst_ni = 1'b1;
      cycle();

      // Single instruction read, response two cycles after grant.
      i_req = 1'b1; i_addr = 32'h100; m_gnt = 1'b1;
      expect_txn(1'b0, 32'hDEADBEEF);
      settle();
      check("t1_m_req", 32'(m_req), 1);
      check("t1_m_addr", m_addr, 32'h100);
      cycle();
      idle();
      d_addr = 32'h1234;
      settle();
      check("idle_mirror_d", m_addr, 32'h1234);
      cycle();
      respond(32'hDEADBEEF);

      // Contention: data wins, then instruction.
      i_req = 1'b1; i_addr = 32'h200;
      d_req = 1'b1; d_addr = 32'h300; d_we = 1'b1; d_be = 4'hC; d_wdata = 32'hCAFE;
      m_gnt = 1'b1;
      expect_txn(1'b1, 32'h11111111);
      settle();
      check("t2_m_addr_d", m_addr, 32'h300);
      check("t2_m_we", 32'(m_we), 1);
      check("t2_m_be", 32'(m_be), 32'hC);
      check("t2_m_wdata", m_wdata, 32'hCAFE);
      cycle();
      d_req = 1'b0; d_we = 1'b0; d_be = 4'hF;
      expect_txn(1'b0, 32'h22222222);
      settle();
      check("t2_m_addr_i", m_addr, 32'h200);
      cycle();
      respond(32'h11111111);
      respond(32'h22222222);

      // Lock on a stalled data request while instruction rises.
      d_req = 1'b1; d_addr = 32'h400;
      settle();
      check("t3_addr_c1", m_addr, 32'h400);
      cycle();
      i_req = 1'b1; i_addr = 32'h500;
      settle();
      check("t3_addr_c2", m_addr, 32'h400);
      cycle();
      settle();
      check("t3_addr_c3", m_addr, 32'h400);
      cycle();
      m_gnt = 1'b1;
      expect_txn(1'b1, 32'h33333333);
      settle();
      check("t3_addr_gnt", m_addr, 32'h400);
      cycle();
      d_req = 1'b0;
      expect_txn(1'b0, 32'h44444444);
      cycle();
      respond(32'h33333333);
      respond(32'h44444444);

      // Lock on a stalled instruction request while data rises.
      i_req = 1'b1; i_addr = 32'h600;
      cycle();
      d_req = 1'b1; d_addr = 32'h700;
      settle();
      check("t3b_addr_lock", m_addr, 32'h600);
      cycle();
      m_gnt = 1'b1;
      expect_txn(1'b0, 32'h12121212);
      settle();
      check("t3b_addr_gnt", m_addr, 32'h600);
      cycle();
      i_req = 1'b0;
      expect_txn(1'b1, 32'h34343434);
      settle();
      check("t3b_addr_d", m_addr, 32'h700);
      cycle();
      respond(32'h12121212);
      respond(32'h34343434);

      // Full at two outstanding, then push and pop together.
      i_req = 1'b1; i_addr = 32'h800; m_gnt = 1'b1;
      expect_txn(1'b0, 32'h55);
      cycle();
      i_req = 1'b0; d_req = 1'b1; d_addr = 32'h900;
      expect_txn(1'b1, 32'h66);
      cycle();
      d_req = 1'b0; i_req = 1'b1; i_addr = 32'hA00;
      settle();
      check("t4_full_req", 32'(m_req), 0);
      cycle();
      m_rvalid = 1'b1; m_rdata = 32'h55;
      settle();
      check("t4_full_pop_req", 32'(m_req), 0);
      cycle();
      m_rvalid = 1'b0;
      expect_txn(1'b0, 32'h77);
      settle();
      check("t4_reopen_req", 32'(m_req), 1);
      cycle();
      respond(32'h66);
      d_req = 1'b1; d_addr = 32'hB00; m_gnt = 1'b1;
      m_rvalid = 1'b1; m_rdata = 32'h77;
      expect_txn(1'b1, 32'h88);
      settle();
      check("t5_pp_req", 32'(m_req), 1);
      cycle();
      idle();
      i_req = 1'b1; i_addr = 32'hC00; m_gnt = 1'b1;
      expect_txn(1'b0, 32'h99);
      cycle();
      settle();
      check("t5_count2_req", 32'(m_req), 0);
      respond(32'h88);
      respond(32'h99);

      // Stray response on an empty FIFO.
      check("t6_err_before", 32'(err), 0);
      m_rvalid = 1'b1; m_rdata = 32'hBAD;
      cycle();
      m_rvalid = 1'b0;
      check("t6_err_set", 32'(err), 1);
      cycle();
      check("t6_err_sticky", 32'(err), 1);

      // Single instruction grant, then held contention.
      i_req = 1'b1; i_addr = 32'hD00; m_gnt = 1'b1;
      expect_txn(1'b0, 32'hABCD);
      cycle();
      respond(32'hABCD);
      for (int k = 0; k < 4; k++) begin
         bit win_d;
`ifdef OBI_ARB_RR_EN
         win_d = (k % 2 == 0);
`else
         win_d = 1'b1;
`endif
         i_req = 1'b1; i_addr = 32'hE00;
         d_req = 1'b1; d_addr = 32'hF00;
         m_gnt = 1'b1;
         m_rvalid = (k > 0);
         m_rdata = 32'h1000 + 32'(k) - 32'd1;
         expect_txn(win_d, 32'h1000 + 32'(k));
         settle();
         check("t7_alt_addr", m_addr, win_d ? 32'hF00 : 32'hE00);
         cycle();
      end
      respond(32'h1003);

      // Reset with a transaction outstanding, then a stray response.
      i_req = 1'b1; i_addr = 32'h40; m_gnt = 1'b1;
      exp_gnt_q.push_back(2'b01);
      cycle();
      idle();
      rst_ni = 1'b0;
      settle();
      check("t8_rst_err", 32'(err), 0);
      check("t8_rst_m_req", 32'(m_req), 0);
      cycle();
      rst_ni = 1'b1;
      cycle();
      m_rvalid = 1'b1; m_rdata = 32'hBAD2;
      cycle();
      m_rvalid = 1'b0;
      check("t8_err_after", 32'(err), 1);
      cycle();

      check("end_gnt_q_empty", 32'(exp_gnt_q.size()), 0);
      check("end_rsp_q_empty", 32'(exp_rsp_q.size()), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      errors++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
